// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and size helpers.
package lsu_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC0,
        ST_ACC1,
        ST_DONE,
        ST_ERR
    } state_e;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_mask = 4'b0001;
            SZ_HALF: size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_nbytes = 3'd1;
            SZ_HALF: size_nbytes = 3'd2;
            default: size_nbytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment: store data/byte-enable shift across a two-word window and load
// shift plus sign/zero extension. Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]        i_size,
    input  logic [1:0]        i_offset,
    input  logic              i_hi,
    input  logic              i_unsigned,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [2*XLEN-1:0] i_rdata,
    output logic [3:0]        o_be,
    output logic [XLEN-1:0]   o_wdata,
    output logic [XLEN-1:0]   o_rdata
);

    logic [7:0]        w_be8;
    logic [2*XLEN-1:0] w_wd64;
    logic [XLEN-1:0]   w_rsh;
    logic              w_sign;

    always_comb begin
        w_be8   = {4'b0000, size_mask(i_size)} << i_offset;
        w_wd64  = {{XLEN{1'b0}}, i_wdata} << {i_offset, 3'b000};
        o_be    = i_hi ? w_be8[7:4] : w_be8[3:0];
        o_wdata = i_hi ? w_wd64[2*XLEN-1:XLEN] : w_wd64[XLEN-1:0];

        w_rsh   = XLEN'(i_rdata >> {i_offset, 3'b000});
        case (i_size)
            SZ_BYTE: begin
                w_sign  = w_rsh[7] & ~i_unsigned;
                o_rdata = {{(XLEN-8){w_sign}}, w_rsh[7:0]};
            end
            SZ_HALF: begin
                w_sign  = w_rsh[15] & ~i_unsigned;
                o_rdata = {{(XLEN-16){w_sign}}, w_rsh[15:0]};
            end
            default: begin
                w_sign  = 1'b0;
                o_rdata = w_rsh;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit: 2-cycle aligned latency, 3 with a split crossing access; stalls the pipe until the response.
// LSU_MISALIGN_SPLIT_EN: split word-crossing accesses instead of raising misalign_exc.
module lsu
    import lsu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            misalign_exc,
    output logic            stall,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    state_e            r_state;
    state_e            w_next;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [1:0]        r_offset;
    logic [XLEN-1:0]   r_wdata;
    logic              w_idle;
    logic              w_accept;
    logic              w_reject;
    logic [2:0]        w_nbytes;
    logic [3:0]        w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_ld;
    logic [2*XLEN-1:0] w_rdata64;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic              w_cross;
    logic              r_cross;
    logic [XLEN-3:0]   r_addr_hi;
    logic [XLEN-1:0]   r_lo_word;
`else
    logic              w_misalign;
`endif

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = w_idle & req_valid;
    assign w_nbytes = size_nbytes(req_size);

`ifdef LSU_MISALIGN_SPLIT_EN
    assign w_cross   = ({1'b0, req_addr[1:0]} + w_nbytes) > 3'd4;
    assign w_reject  = 1'b0;
    assign w_rdata64 = r_cross ? {mem_rdata, r_lo_word} : {{XLEN{1'b0}}, mem_rdata};
`else
    // nbytes-1 is the low-address mask that must be clear for a naturally aligned access
    assign w_misalign = |(req_addr[1:0] & (w_nbytes[1:0] - 2'd1));
    assign w_reject   = w_misalign;
    assign w_rdata64  = {{XLEN{1'b0}}, mem_rdata};
`endif

    lsu_align u_align (
        .i_size     (w_idle ? req_size : r_size),
        .i_offset   (w_idle ? req_addr[1:0] : r_offset),
        .i_hi       (r_state == ST_ACC0),
        .i_unsigned (r_unsigned),
        .i_wdata    (w_idle ? req_wdata : r_wdata),
        .i_rdata    (w_rdata64),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_rdata    (w_ld)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (req_valid) w_next = w_reject ? ST_ERR : ST_ACC0;
`ifdef LSU_MISALIGN_SPLIT_EN
            ST_ACC0: w_next = r_cross ? ST_ACC1 : ST_DONE;
            ST_ACC1: w_next = ST_DONE;
`else
            ST_ACC0: w_next = ST_DONE;
`endif
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready    = w_idle & ~rst;
        stall        = (req_valid & w_idle) | (r_state == ST_ACC0) | (r_state == ST_ACC1);
        resp_valid   = (r_state == ST_DONE) | (r_state == ST_ERR);
`ifdef LSU_MISALIGN_SPLIT_EN
        misalign_exc = 1'b0;
`else
        misalign_exc = (r_state == ST_ERR);
`endif
        resp_rdata   = ((r_state == ST_DONE) && !r_we) ? w_ld : '0;
    end

    // mem_* are loaded one edge ahead of the state that owns them
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_be     <= 4'b0000;
            mem_wdata  <= '0;
            r_we       <= 1'b0;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_offset   <= 2'b00;
            r_wdata    <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_cross    <= 1'b0;
            r_addr_hi  <= '0;
            r_lo_word  <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            mem_be <= 4'b0000;
            if (w_accept) begin
                r_we       <= req_we;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_offset   <= req_addr[1:0];
                r_wdata    <= req_wdata;
`ifdef LSU_MISALIGN_SPLIT_EN
                r_cross    <= w_cross;
                r_addr_hi  <= req_addr[XLEN-1:2];
`endif
                if (!w_reject) begin
                    mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
                    mem_we    <= req_we;
                    mem_be    <= w_be;
                    mem_wdata <= w_wdata;
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            if ((r_state == ST_ACC0) && r_cross) begin
                mem_addr  <= {r_addr_hi + {{(XLEN-3){1'b0}}, 1'b1}, 2'b00};
                mem_we    <= r_we;
                mem_be    <= w_be;
                mem_wdata <= w_wdata;
            end
            if (r_state == ST_ACC1) r_lo_word <= mem_rdata;
`endif
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a word-addressed BRAM model and a response scoreboard.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, misalign_exc, stall, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [3:0]  mem_be;

    always #5 clk = ~clk;

    lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .misalign_exc(misalign_exc), .stall(stall),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // BRAM model: read-first, data returned one cycle after the address
    logic [31:0] mem_model [logic [29:0]];
    logic [31:0] mw;
    always @(posedge clk) begin
        mw = mem_model.exists(mem_addr[31:2]) ? mem_model[mem_addr[31:2]] : 32'h0;
        mem_rdata <= mw;
        if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mw[8*b +: 8] = mem_wdata[8*b +: 8];
            mem_model[mem_addr[31:2]] = mw;
        end
    end

    typedef struct { logic [31:0] rdata; logic exc; int lat; } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int lat;
    logic [31:0] a_addr [2];
    logic [31:0] a_wdata [2];
    logic [3:0]  a_be [2];
    logic        a_we [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_exc, input int exp_lat);
        exp_t e;
        e.rdata = exp_rdata; e.exc = exp_exc; e.lat = exp_lat;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        #1;
        check({tag, " ready"}, {31'b0, req_ready}, 32'd1);
        check({tag, " stall_req"}, {31'b0, stall}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_addr[i] = 32'h0; a_wdata[i] = 32'h0; a_be[i] = 4'h0; a_we[i] = 1'b0;
        end
        lat = 1;
        while (!resp_valid && lat < 8) begin
            if (lat <= 2) begin
                a_addr[lat-1] = mem_addr; a_wdata[lat-1] = mem_wdata;
                a_be[lat-1] = mem_be; a_we[lat-1] = mem_we;
            end
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        check({tag, " resp_valid"}, {31'b0, resp_valid}, 32'd1);
        check({tag, " rdata"}, resp_rdata, e.rdata);
        check({tag, " exc"}, {31'b0, misalign_exc}, {31'b0, e.exc});
        check({tag, " latency"}, 32'(lat), 32'(e.lat));
        check({tag, " idle_bus"}, {27'b0, mem_we, mem_be}, 32'd0);
        check({tag, " stall_resp"}, {31'b0, stall}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        mem_model[30'h0800] = 32'h8001_1234;
        mem_model[30'h0C00] = 32'h4433_2211;
        mem_model[30'h0C01] = 32'h8877_6655;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        check("rst we_be", {27'b0, mem_we, mem_be}, 32'h0);
        check("rst resp", {30'b0, resp_valid, misalign_exc}, 32'h0);
        check("rst rdata", resp_rdata, 32'h0);
        check("rst stall", {31'b0, stall}, 32'h0);
        check("rst ready", {31'b0, req_ready}, 32'h0);
        rst = 1'b0;
        #1;
        check("ready after rst", {31'b0, req_ready}, 32'd1);

        run("sb", 1'b1, SZ_BYTE, 1'b0, 32'h1003, 32'h0000_00AB, 32'h0, 1'b0, 2);
        check("sb addr", a_addr[0], 32'h1000);
        check("sb be", {28'b0, a_be[0]}, 32'b1000);
        check("sb wdata", a_wdata[0], 32'hAB00_0000);
        check("sb we", {31'b0, a_we[0]}, 32'd1);

        run("lh", 1'b0, SZ_HALF, 1'b0, 32'h2002, 32'h0, 32'hFFFF_8001, 1'b0, 2);
        check("lh addr", a_addr[0], 32'h2000);
        check("lh be", {28'b0, a_be[0]}, 32'b1100);
        check("lh we", {31'b0, a_we[0]}, 32'd0);
        run("lhu", 1'b0, SZ_HALF, 1'b1, 32'h2002, 32'h0, 32'h0000_8001, 1'b0, 2);
        run("lb", 1'b0, SZ_BYTE, 1'b0, 32'h1003, 32'h0, 32'hFFFF_FFAB, 1'b0, 2);
        run("lbu", 1'b0, SZ_BYTE, 1'b1, 32'h1003, 32'h0, 32'h0000_00AB, 1'b0, 2);

        run("sw", 1'b1, SZ_WORD, 1'b0, 32'h1004, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
        check("sw be", {28'b0, a_be[0]}, 32'b1111);
        run("lw", 1'b0, SZ_WORD, 1'b0, 32'h1004, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
        run("lb1", 1'b0, SZ_BYTE, 1'b0, 32'h1005, 32'h0, 32'hFFFF_FFBE, 1'b0, 2);
        run("lbu2", 1'b0, SZ_BYTE, 1'b1, 32'h1006, 32'h0, 32'h0000_00AD, 1'b0, 2);
        run("lh0", 1'b0, SZ_HALF, 1'b0, 32'h1004, 32'h0, 32'hFFFF_BEEF, 1'b0, 2);
        run("sh", 1'b1, SZ_HALF, 1'b0, 32'h100A, 32'h1234_5678, 32'h0, 1'b0, 2);
        check("sh be", {28'b0, a_be[0]}, 32'b1100);
        check("sh wdata", a_wdata[0], 32'h5678_0000);
        run("lw2", 1'b0, SZ_WORD, 1'b0, 32'h1008, 32'h0, 32'h5678_0000, 1'b0, 2);
        run("lsz3", 1'b0, 2'b11, 1'b0, 32'h1004, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);

`ifdef LSU_MISALIGN_SPLIT_EN
        run("slw", 1'b0, SZ_WORD, 1'b0, 32'h3003, 32'h0, 32'h7766_5544, 1'b0, 3);
        check("slw addr0", a_addr[0], 32'h3000);
        check("slw addr1", a_addr[1], 32'h3004);
        run("ssh", 1'b1, SZ_HALF, 1'b0, 32'h3007, 32'h0000_BEEF, 32'h0, 1'b0, 3);
        check("ssh addr0", a_addr[0], 32'h3004);
        check("ssh be0", {28'b0, a_be[0]}, 32'b1000);
        check("ssh wd0", a_wdata[0], 32'hEF00_0000);
        check("ssh addr1", a_addr[1], 32'h3008);
        check("ssh be1", {28'b0, a_be[1]}, 32'b0001);
        check("ssh wd1", a_wdata[1], 32'h0000_00BE);
        check("ssh we1", {31'b0, a_we[1]}, 32'd1);
        run("slhu", 1'b0, SZ_HALF, 1'b1, 32'h3007, 32'h0, 32'h0000_BEEF, 1'b0, 3);
        run("lh_in", 1'b0, SZ_HALF, 1'b0, 32'h2001, 32'h0, 32'h0000_0112, 1'b0, 2);

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_addr = 32'h3005;
        req_wdata = 32'h1122_3344;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rst1 acc1 we", {31'b0, mem_we}, 32'd1);
        check("rst1 acc1 addr", mem_addr, 32'h3008);
`else
        run("mis lw", 1'b0, SZ_WORD, 1'b0, 32'h4002, 32'h0, 32'h0, 1'b1, 1);
        run("mis lh", 1'b0, SZ_HALF, 1'b0, 32'h2001, 32'h0, 32'h0, 1'b1, 1);
        run("mis sw", 1'b1, SZ_WORD, 1'b0, 32'h1006, 32'h5555_5555, 32'h0, 1'b1, 1);
        run("lw3", 1'b0, SZ_WORD, 1'b0, 32'h1004, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_addr = 32'h1010;
        req_wdata = 32'h1122_3344;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst1 acc0 we", {31'b0, mem_we}, 32'd1);
`endif
        rst = 1'b1;
        @(negedge clk);
        check("rst1 we_be", {27'b0, mem_we, mem_be}, 32'h0);
        check("rst1 resp", {31'b0, resp_valid}, 32'h0);
        rst = 1'b0;
        #1;
        check("rst1 ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        check("rst1 no resp", {31'b0, resp_valid}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
